vga_bar_renderer: RTL and testbench

VGA_BAR_RENDERER -- requirements
Module: vga_bar_renderer

---
 rtl/vga_pkg.sv | 20 ++
 rtl/bar_table.sv | 50 +++++
 rtl/vga_bar_renderer.sv | 150 +++++++++++++++
 tb/tb_vga_bar_renderer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the spectrum-bar VGA renderer: active resolution,
// swap-control states and the RGB triple.
package vga_pkg;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_SWAP    = 2'd2
  } bar_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/bar_table.sv
// Two banks of N_BARS magnitude registers: one write port, one combinational
// read port, each with its own bank select. Out-of-range indices never match.
module bar_table #(
  parameter int N_BARS = 16,
  parameter int MAG_W  = 9,
  parameter int IDX_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic             i_wr_bank,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [MAG_W-1:0] i_wr_mag,
  input  logic             i_rd_bank,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [MAG_W-1:0] o_rd_mag
);

  logic [MAG_W-1:0] mem [2][N_BARS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_BARS; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (i_we) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_BARS; i++) begin
          if (i_wr_bank == 1'(b) && i_wr_idx == IDX_W'(i)) begin
            mem[b][i] <= i_wr_mag;
          end
        end
      end
    end
  end

  always_comb begin
    o_rd_mag = '0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N_BARS; i++) begin
        if (i_rd_bank == 1'(b) && i_rd_idx == IDX_W'(i)) begin
          o_rd_mag = mem[b][i];
        end
      end
    end
  end

endmodule

// File: rtl/vga_bar_renderer.sv
// Spectrum-bar renderer: double-buffered bar heights swapped at frame end,
// and a fixed two-stage pixel pipeline from (x, y, blank_n) to RGB.
module vga_bar_renderer #(
  parameter int N_BARS  = 16,
  parameter int BAR_W   = 40,
  parameter int BAR_GAP = 4,
  parameter int H_ACT   = vga_pkg::H_ACT,
  parameter int V_ACT   = vga_pkg::V_ACT,
  parameter int MAG_W   = 9,
  parameter int IDX_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bar_valid,
  output logic             o_bar_ready,
  input  logic [IDX_W-1:0] i_bar_idx,
  input  logic [MAG_W-1:0] i_bar_mag,
  input  logic             i_frame_done,
  input  logic [10:0]      i_vga_x,
  input  logic [10:0]      i_vga_y,
  input  logic             i_vga_blank_n,
  output logic [7:0]       o_vga_r,
  output logic [7:0]       o_vga_g,
  output logic [7:0]       o_vga_b,
  output logic             o_swap_done
);

  import vga_pkg::*;

  localparam int               COL_W    = $clog2(BAR_W);
  localparam logic [COL_W-1:0] LIT_COLS = COL_W'(BAR_W - BAR_GAP);
  localparam logic [MAG_W-1:0] MAG_MAX  = MAG_W'(V_ACT);
  localparam logic [IDX_W:0]   N_BARS_X = (IDX_W + 1)'(N_BARS);

  function automatic logic [MAG_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
    return (m > MAG_MAX) ? MAG_MAX : m;
  endfunction

  function automatic rgb_t bar_colour(input logic signed [11:0] h);
    rgb_t c;
    c.r = h[8:1];
    c.g = 8'hFF - h[8:1];
    c.b = 8'h40;
    return c;
  endfunction

  bar_state_t state;
  logic       buf_sel;
  logic       frame_end;
  logic       wr_hit;

  assign frame_end = i_vga_blank_n && (i_vga_x == 11'(H_ACT - 1))
                     && (i_vga_y == 11'(V_ACT - 1));
  assign wr_hit    = i_bar_valid && o_bar_ready && ({1'b0, i_bar_idx} < N_BARS_X);

  // Swap control: ready and swap pulse are registered off the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      buf_sel     <= 1'b0;
      o_bar_ready <= 1'b0;
      o_swap_done <= 1'b0;
    end else begin
      o_swap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_bar_ready <= 1'b1;
          if (i_frame_done) begin
            state       <= S_PENDING;
            o_bar_ready <= 1'b0;
          end
        end
        S_PENDING: begin
          if (frame_end) begin
            state       <= S_SWAP;
            buf_sel     <= ~buf_sel;
            o_swap_done <= 1'b1;
          end
        end
        S_SWAP: begin
          state       <= S_IDLE;
          o_bar_ready <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          o_bar_ready <= 1'b0;
        end
      endcase
    end
  end

  logic             vld_p1;
  logic [IDX_W-1:0] bar_p1;
  logic [COL_W-1:0] col_p1;
  logic signed [11:0] h_p1;
  logic             bank_p1;
  logic [MAG_W-1:0] rd_mag;
  logic             lit;
  rgb_t             rgb_p2;

  bar_table #(
    .N_BARS (N_BARS),
    .MAG_W  (MAG_W),
    .IDX_W  (IDX_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (wr_hit),
    .i_wr_bank (~buf_sel),
    .i_wr_idx  (i_bar_idx),
    .i_wr_mag  (sat_mag(i_bar_mag)),
    .i_rd_bank (bank_p1),
    .i_rd_idx  (bar_p1),
    .o_rd_mag  (rd_mag)
  );

  // Stage 1: bar index, column within pitch, height above bottom row, bank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      bar_p1  <= '0;
      col_p1  <= '0;
      h_p1    <= '0;
      bank_p1 <= 1'b0;
    end else begin
      vld_p1  <= i_vga_blank_n;
      bar_p1  <= IDX_W'(i_vga_x / BAR_W);
      col_p1  <= COL_W'(i_vga_x % BAR_W);
      h_p1    <= $signed(12'(V_ACT - 1)) - $signed({1'b0, i_vga_y});
      bank_p1 <= buf_sel;
    end
  end

  assign lit = vld_p1 && (col_p1 < LIT_COLS) && !h_p1[11]
               && (h_p1 < $signed({{(12 - MAG_W){1'b0}}, rd_mag}));

  // Stage 2: front-table lookup and colour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_p2 <= '0;
    end else begin
      rgb_p2 <= lit ? bar_colour(h_p1) : '0;
    end
  end

  assign o_vga_r = rgb_p2.r;
  assign o_vga_g = rgb_p2.g;
  assign o_vga_b = rgb_p2.b;

endmodule

// File: tb/tb_vga_bar_renderer.sv
// Directed bench for vga_bar_renderer: swap handshake, pixel colours,
// gap/blanking, saturation, dropped writes and mid-frame reset.
module tb_vga_bar_renderer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_bar_valid;
  logic        o_bar_ready;
  logic [4:0]  i_bar_idx;
  logic [8:0]  i_bar_mag;
  logic        i_frame_done;
  logic [10:0] i_vga_x;
  logic [10:0] i_vga_y;
  logic        i_vga_blank_n;
  logic [7:0]  o_vga_r;
  logic [7:0]  o_vga_g;
  logic [7:0]  o_vga_b;
  logic        o_swap_done;

  int errors = 0;
  int checks = 0;

  vga_bar_renderer #(.IDX_W(5)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_bar_valid   (i_bar_valid),
    .o_bar_ready   (o_bar_ready),
    .i_bar_idx     (i_bar_idx),
    .i_bar_mag     (i_bar_mag),
    .i_frame_done  (i_frame_done),
    .i_vga_x       (i_vga_x),
    .i_vga_y       (i_vga_y),
    .i_vga_blank_n (i_vga_blank_n),
    .o_vga_r       (o_vga_r),
    .o_vga_g       (o_vga_g),
    .o_vga_b       (o_vga_b),
    .o_swap_done   (o_swap_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int x, input int y, input logic bn);
    i_vga_x       = 11'(x);
    i_vga_y       = 11'(y);
    i_vga_blank_n = bn;
  endtask

  task automatic pix(input int x, input int y, input logic bn);
    set_pix(x, y, bn);
    tick();
    tick();
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, o_vga_r, o_vga_g, o_vga_b};
  endfunction

  task automatic write(input int idx, input int mag, input logic fd);
    i_bar_valid  = 1'b1;
    i_bar_idx    = 5'(idx);
    i_bar_mag    = 9'(mag);
    i_frame_done = fd;
    tick();
    i_bar_valid  = 1'b0;
    i_frame_done = 1'b0;
  endtask

  task automatic pulse_frame_done();
    i_frame_done = 1'b1;
    tick();
    i_frame_done = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_bar_valid = 1'b0;
    i_bar_idx = '0;
    i_bar_mag = '0;
    i_frame_done = 1'b0;
    set_pix(0, 0, 1'b0);
    tick();
    tick();
    check("rst_ready", 32'(o_bar_ready), 32'd0);
    check("rst_swap", 32'(o_swap_done), 32'd0);
    check("rst_rgb", rgb(), 32'h0);
    i_rst_n = 1'b1;
    tick();
    check("ready_after_rel", 32'(o_bar_ready), 32'd1);

    // bar 3 = 100 into back bank, then swap at frame end
    write(3, 100, 1'b0);
    pulse_frame_done();
    check("ready_pending", 32'(o_bar_ready), 32'd0);
    set_pix(100, 200, 1'b1);
    tick();
    check("no_early_swap", 32'(o_swap_done), 32'd0);
    check("ready_pending2", 32'(o_bar_ready), 32'd0);
    set_pix(639, 479, 1'b1);
    tick();
    check("swap_pulse", 32'(o_swap_done), 32'd1);
    check("ready_in_swap", 32'(o_bar_ready), 32'd0);
    tick();
    check("swap_one_cycle", 32'(o_swap_done), 32'd0);
    check("ready_after_swap", 32'(o_bar_ready), 32'd1);

    pix(125, 479, 1'b1);
    check("h0_lit", rgb(), 32'h00FF40);
    pix(125, 380, 1'b1);
    check("h99_lit", rgb(), 32'h31CE40);
    pix(125, 379, 1'b1);
    check("h100_dark", rgb(), 32'h0);
    pix(156, 479, 1'b1);
    check("gap_dark", rgb(), 32'h0);
    pix(125, 479, 1'b0);
    check("blank_dark", rgb(), 32'h0);
    set_pix(125, 479, 1'b1);
    tick();
    check("latency_1cyc", rgb(), 32'h0);
    tick();
    check("latency_2cyc", rgb(), 32'h00FF40);

    // saturated bar 0 and an out-of-range index, then swap
    write(0, 511, 1'b0);
    write(20, 300, 1'b0);
    check("ready_idx20", 32'(o_bar_ready), 32'd1);
    pulse_frame_done();
    set_pix(639, 479, 1'b1);
    tick();
    check("swap2_pulse", 32'(o_swap_done), 32'd1);
    tick();
    pix(0, 0, 1'b1);
    check("sat_top_row", rgb(), 32'hEF1040);
    pix(35, 479, 1'b1);
    check("sat_x35", rgb(), 32'h00FF40);
    pix(36, 479, 1'b1);
    check("sat_gap36", rgb(), 32'h0);
    pix(125, 479, 1'b1);
    check("no_copy_bar3", rgb(), 32'h0);
    pix(165, 479, 1'b1);
    check("idx20_dropped", rgb(), 32'h0);

    // two frame_done pulses in one frame give a single swap
    pulse_frame_done();
    pulse_frame_done();
    set_pix(639, 479, 1'b1);
    tick();
    check("dbl_fd_swap", 32'(o_swap_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dbl_fd_no_second", 32'(o_swap_done), 32'd0);
    end
    set_pix(0, 0, 1'b0);

    // write coinciding with frame_done is displayed after the swap
    write(5, 50, 1'b1);
    check("ready_after_wr_fd", 32'(o_bar_ready), 32'd0);
    set_pix(639, 479, 1'b1);
    tick();
    check("wr_fd_swap", 32'(o_swap_done), 32'd1);
    tick();
    pix(205, 430, 1'b1);
    check("wr_fd_h49", rgb(), 32'h18E740);
    pix(205, 429, 1'b1);
    check("wr_fd_h50", rgb(), 32'h0);

    // reset while a swap is pending
    pulse_frame_done();
    pix(0, 479, 1'b1);
    check("pre_rst_lit", rgb(), 32'h00FF40);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_rgb_async", rgb(), 32'h0);
    check("rst_ready_async", 32'(o_bar_ready), 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("first_out_black", rgb(), 32'h0);
    set_pix(639, 479, 1'b1);
    tick();
    check("pending_dropped", 32'(o_swap_done), 32'd0);
    tick();
    check("pending_dropped2", 32'(o_swap_done), 32'd0);
    pix(0, 479, 1'b1);
    check("front_cleared", rgb(), 32'h0);
    pulse_frame_done();
    set_pix(639, 479, 1'b1);
    tick();
    check("swap_after_rst", 32'(o_swap_done), 32'd1);
    tick();
    pix(205, 430, 1'b1);
    check("back_cleared", rgb(), 32'h0);
    pix(0, 479, 1'b1);
    check("back_cleared_b0", rgb(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
